instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Program loader that writes a byte stream into the single-cycle core's instruction memory before execution. It accepts bytes over a valid/ready stream, assembles them little-endian into 32-bit instruction words, and issues one-cycle write strobes with word-aligned byte addresses to the instruction memory write port. While loading, it holds the core in reset. It is the write-side counterpart of the instruction memory's fetch read port.

## Interface
- DEPTH, 1024, instruction memory size in 32-bit words; power of two.
- LEN_W, 11, width of the word-count input; must be at least log2(DEPTH)+1.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a load; sampled only in IDLE.
- base_addr  input  32  byte address of the first word; bits [1:0] are ignored and treated as 0.
- len_words  input  LEN_W  number of words to load; sampled with start.
- s_data  input  8  stream byte.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  loader accepts a byte this cycle.
- WE  output  1  instruction memory write strobe, one cycle per word.
- WA  output  32  write byte address; always word aligned.
- WD  output  32  write data.
- busy  output  1  load in progress.
- cpu_hold  output  1  holds the core in reset; equals busy.
- done  output  1  one-cycle pulse when a load completes.
- err  output  1  one-cycle pulse when a start is rejected.

## Operation
- States: IDLE, LOAD, FINISH.
- IDLE, start=1:
  - If base_addr[31:2] + len_words > DEPTH: err pulses next cycle and the block stays in IDLE.
  - Else if len_words == 0: go to FINISH and pulse done; no writes.
  - Else: latch the word address base_addr[31:2], set the remaining count to len_words, clear the byte index, and go to LOAD.
- LOAD:
  - s_ready=1. A byte is accepted when s_valid && s_ready.
  - Byte index k (0..3) is placed at WD bits [8k+7:8k]. The first byte becomes the LSB.
  - When the 4th byte is accepted, the word is registered. On the next cycle WE=1, WA={word_addr,2'b00}, and WD is the assembled word.
  - word_addr then increments, the remaining count decrements, and the byte index returns to 0.
  - Byte acceptance continues uninterrupted; back-to-back bytes are allowed every cycle.
  - When the last word is accepted, s_ready drops in the following cycle, and the state goes to FINISH after its write.
- FINISH: done=1 for one cycle; busy and cpu_hold fall in the same cycle; return to IDLE.
- start is ignored when not in IDLE. s_valid is ignored when s_ready=0, and those bytes are not consumed.
- Address arithmetic uses word granularity and never wraps. The bounds check at start guarantees that the final word address is at most DEPTH-1.
- If s_valid stalls mid-word, the partial word is retained indefinitely. There is no timeout.

## Timing
- Reset (asynchronous):
  - State goes to IDLE.
  - s_ready, WE, busy, cpu_hold, done and err are 0.
  - WA and WD are 0.
  - Byte index, count and partial word are cleared.
- Reset mid-load aborts immediately. Words already written remain in memory; the partial word is discarded.
- start accepted at cycle T: busy, cpu_hold and s_ready are 1 from T+1.
- 4th byte of a word accepted at cycle N: WE=1 at N+1 only.
- Last word's 4th byte at cycle N: WE at N+1, s_ready=0 from N+1, done=1 at N+2, busy=0 at N+2.
- Rejected start at T: err=1 at T+1; busy stays 0.
- start with len_words=0 at T: busy=1 and done=1 at T+1; busy=0 at T+2.
- Minimum load time for L words with continuous bytes: 4L+2 cycles from start to done.

## Test plan
- Basic load: base 0x0, len 1, bytes 03,A3,C4,FF -> one WE pulse with WA=0x0 and WD=0xFFC4A303; done 2 cycles after the 4th byte; cpu_hold low afterwards.
- Streaming: base 0x100, len 3, 12 back-to-back bytes 00..0B -> WE at WA 0x100, 0x104 and 0x108 with WD 0x03020100, 0x07060504 and 0x0B0A0908; s_ready low after the 12th byte.
- Gapped valid: the same 4 bytes with s_valid low for 5 cycles between bytes 2 and 3 -> identical WD; no spurious WE; busy stays high throughout.
- Bounds and misalignment:
  - base 0xFFC (word 1023), len 1 -> accepted; WA=0xFFC.
  - base 0xFFC, len 2 -> err pulse; no WE; busy 0.
  - base 0x102 -> WA=0x100.
- Zero length and ignored start: len 0 -> done pulse with no WE; start asserted during LOAD -> no effect on address or count.
- Reset mid-load: assert reset after 6 of 8 bytes (len 2) -> first word written; all outputs 0 immediately. A fresh load then starts with byte index 0.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Program loader: assembles a little-endian byte stream into 32-bit words and writes them
// to instruction memory, holding the core in reset while the load is in progress.
module instr_mem_loader #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned LEN_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] len_words,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             WE,
  output logic [31:0]      WA,
  output logic [31:0]      WD,
  output logic             busy,
  output logic             cpu_hold,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {StIdle, StLoad, StFinish} state_e;

  state_e           state_q, state_d;
  logic [29:0]      word_addr_q, word_addr_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [23:0]      partial_q, partial_d;
  logic             s_ready_q, s_ready_d;
  logic             we_q, we_d;
  logic [31:0]      wa_q, wa_d;
  logic [31:0]      wd_q, wd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic        accept;
  logic [32:0] end_word;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^base_addr[1:0];
  assign accept   = s_ready_q & s_valid;
  // One past the last word touched; wide enough that it can never wrap.
  assign end_word = {3'b000, base_addr[31:2]} + 33'(len_words);

  always_comb begin
    state_d     = state_q;
    word_addr_d = word_addr_q;
    count_d     = count_q;
    byte_idx_d  = byte_idx_q;
    partial_d   = partial_q;
    s_ready_d   = s_ready_q;
    we_d        = 1'b0;
    wa_d        = wa_q;
    wd_d        = wd_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (end_word > 33'(DEPTH)) begin
            err_d = 1'b1;
          end else if (len_words == '0) begin
            state_d = StFinish;
            busy_d  = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d     = StLoad;
            word_addr_d = base_addr[31:2];
            count_d     = len_words;
            byte_idx_d  = 2'd0;
            partial_d   = '0;
            busy_d      = 1'b1;
            s_ready_d   = 1'b1;
          end
        end
      end
      StLoad: begin
        if (accept) begin
          if (byte_idx_q == 2'd3) begin
            we_d        = 1'b1;
            wa_d        = {word_addr_q, 2'b00};
            wd_d        = {s_data, partial_q};
            word_addr_d = word_addr_q + 30'd1;
            count_d     = count_q - LEN_W'(1);
            byte_idx_d  = 2'd0;
            if (count_q == LEN_W'(1)) begin
              s_ready_d = 1'b0;
            end
          end else begin
            // Shift right so that after three bytes partial holds {b2, b1, b0}.
            partial_d  = {s_data, partial_q[23:8]};
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end else if (count_q == '0) begin
          state_d = StFinish;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      StFinish: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      word_addr_q <= '0;
      count_q     <= '0;
      byte_idx_q  <= '0;
      partial_q   <= '0;
      s_ready_q   <= 1'b0;
      we_q        <= 1'b0;
      wa_q        <= '0;
      wd_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_addr_q <= word_addr_d;
      count_q     <= count_d;
      byte_idx_q  <= byte_idx_d;
      partial_q   <= partial_d;
      s_ready_q   <= s_ready_d;
      we_q        <= we_d;
      wa_q        <= wa_d;
      wd_q        <= wd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign s_ready  = s_ready_q;
  assign WE       = we_q;
  assign WA       = wa_q;
  assign WD       = wd_q;
  assign busy     = busy_q;
  assign cpu_hold = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed and randomized loads compared against a word-list model.
module tb_instr_mem_loader;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LEN_W = 11;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [31:0]      base_addr;
  logic [LEN_W-1:0] len_words;
  logic [7:0]       s_data;
  logic             s_valid;
  logic             s_ready;
  logic             WE;
  logic [31:0]      WA;
  logic [31:0]      WD;
  logic             busy;
  logic             cpu_hold;
  logic             done;
  logic             err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] wa_seen[$];
  logic [31:0] wd_seen[$];
  int          we_cyc[$];

  instr_mem_loader #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len_words(len_words),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .WE(WE), .WA(WA), .WD(WD),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (WE === 1'b1) begin
      wa_seen.push_back(WA);
      wd_seen.push_back(WD);
      we_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wa_seen.delete();
    wd_seen.delete();
    we_cyc.delete();
  endtask

  // Compare captured writes against the expected word list for the first nwords words.
  task automatic check_writes(input logic [31:0] base, input int nwords, input logic [7:0] b[$],
                              input int acc[$]);
    check("we_count", 64'(wa_seen.size()), 64'(nwords));
    for (int i = 0; i < nwords && i < wa_seen.size(); i++) begin
      check("wa", wa_seen[i], (base & 32'hFFFF_FFFC) + 32'(4 * i));
      check("wd", wd_seen[i], {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]});
      check("we_time", 64'(we_cyc[i]), 64'(acc[4*i+3]));
    end
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_ready"}, s_ready, 0);
    check({tag, "_we"}, WE, 0);
    check({tag, "_wa"}, WA, 0);
    check({tag, "_wd"}, WD, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_hold"}, cpu_hold, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic run_load(input logic [31:0] base, input int len, input logic [7:0] b[$],
                          input int max_gap, input int gap_idx, input int gap_len,
                          input bit mid_start, input int abort_after);
    int acc[$];
    int t;
    int gap;
    logic rdy;
    int nbytes;
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; len_words = LEN_W'(len);
    @(posedge clk); #1;
    start = 1'b0; base_addr = $urandom; len_words = LEN_W'($urandom);
    @(negedge clk);
    check("start_busy", busy, 1);
    check("start_hold", cpu_hold, 1);
    check("start_ready", s_ready, 1);
    @(posedge clk); #1;
    nbytes = (abort_after >= 0) ? abort_after : 4 * len;
    for (int i = 0; i < nbytes; i++) begin
      gap = (i == gap_idx) ? gap_len : int'($urandom_range(max_gap, 0));
      s_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      s_valid = 1'b1;
      s_data  = b[i];
      if (mid_start && i == 2) begin
        start = 1'b1; base_addr = 32'h0; len_words = LEN_W'(1);
      end
      t = 0;
      forever begin
        @(negedge clk);
        rdy = s_ready;
        check("busy_load", busy, 1);
        @(posedge clk); #1;
        start = 1'b0;
        if (rdy) break;
        t++;
        if (t > 50) begin
          check("ready_timeout", 0, 1);
          s_valid = 1'b0;
          return;
        end
      end
      acc.push_back(cyc);
    end
    s_valid = 1'b0;
    if (abort_after >= 0) begin
      #2 reset = 1'b1;
      #1 all_zero("abort");
      check_writes(base, abort_after / 4, b, acc);
      @(negedge clk);
      reset = 1'b0;
      return;
    end
    @(negedge clk);
    check("ready_drop", s_ready, 0);
    check("we_last", WE, 1);
    t = 0;
    while (done !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("done_time", 64'(cyc), 64'(acc[acc.size()-1] + 1));
    check("busy_at_done", busy, 0);
    check("hold_at_done", cpu_hold, 0);
    @(negedge clk);
    check("done_pulse", done, 0);
    check_writes(base, len, b, acc);
  endtask

  task automatic run_reject(input logic [31:0] base, input int len);
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; len_words = LEN_W'(len);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("rej_err", err, 1);
    check("rej_busy", busy, 0);
    @(negedge clk);
    check("rej_err_pulse", err, 0);
    check("rej_ready", s_ready, 0);
    check("rej_no_we", 64'(wa_seen.size()), 0);
  endtask

  initial begin : main
    logic [7:0] bq[$];
    int w;
    int len;
    reset = 1'b1; start = 1'b0; base_addr = '0; len_words = '0; s_data = '0; s_valid = 1'b0;
    #1 all_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Basic single word.
    bq = '{8'h03, 8'hA3, 8'hC4, 8'hFF};
    run_load(32'h0, 1, bq, 0, -1, 0, 1'b0, -1);
    check("basic_wd", wd_seen.size() > 0 ? wd_seen[0] : 32'hx, 32'hFFC4_A303);

    // Streaming three words back to back.
    bq.delete();
    for (int i = 0; i < 12; i++) bq.push_back(8'(i));
    run_load(32'h100, 3, bq, 0, -1, 0, 1'b0, -1);

    // Five idle cycles between the second and third byte.
    bq = '{8'h03, 8'hA3, 8'hC4, 8'hFF};
    run_load(32'h40, 1, bq, 0, 2, 5, 1'b0, -1);

    // Bounds and misalignment.
    run_load(32'hFFC, 1, bq, 1, -1, 0, 1'b0, -1);
    run_reject(32'hFFC, 2);
    run_reject(32'h8000_0000, 1);
    run_load(32'h102, 1, bq, 0, -1, 0, 1'b0, -1);

    // Zero length.
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 32'h200; len_words = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_busy", busy, 1);
    check("zero_done", done, 1);
    @(negedge clk);
    check("zero_busy_fall", busy, 0);
    check("zero_done_pulse", done, 0);
    check("zero_no_we", 64'(wa_seen.size()), 0);

    // Start pulsed during a load.
    bq.delete();
    for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
    run_load(32'h300, 2, bq, 1, -1, 0, 1'b1, -1);

    // Reset after six of eight bytes, then a fresh load.
    bq.delete();
    for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
    run_load(32'h500, 2, bq, 0, -1, 0, 1'b0, 6);
    bq.delete();
    for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
    run_load(32'h504, 2, bq, 1, -1, 0, 1'b0, -1);

    // Randomized loads and rejects.
    for (int n = 0; n < 8; n++) begin
      len = int'($urandom_range(5, 1));
      w = int'($urandom_range(DEPTH - len, 0));
      bq.delete();
      for (int i = 0; i < 4 * len; i++) bq.push_back(8'($urandom));
      run_load(32'(w * 4) | 32'($urandom_range(3, 0)), len, bq, 2, -1, 0, 1'b0, -1);
    end
    for (int n = 0; n < 4; n++) begin
      w = int'($urandom_range(DEPTH - 1, 0));
      run_reject(32'(w * 4), DEPTH - w + 1 + int'($urandom_range(5, 0)));
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
